// File: rtl/aes_encipher_ctrl.sv
// AES encipher round sequencer: latches a block, walks round keys 0..N through an
// external combinational round function and captures the final ciphertext.
module aes_encipher_ctrl #(
  parameter int unsigned AES_128_ROUNDS = 10,
  parameter int unsigned AES_256_ROUNDS = 14
) (
  input  logic         clk_i,
  input  logic         reset_i,
  input  logic         next_i,
  input  logic         keylen_i,
  input  logic [127:0] block_i,
  input  logic [127:0] round_key_i,
  output logic [3:0]   round_nr_o,
  output logic [1:0]   round_type_o,
  output logic [127:0] state_out_o,
  input  logic [127:0] round_result_i,
  output logic         ready_o,
  output logic         result_valid_o,
  output logic [127:0] result_o
);

  typedef enum logic [1:0] {IDLE, INIT, ROUNDS, DONE} state_e;

  localparam logic [1:0] RT_INIT  = 2'd0;
  localparam logic [1:0] RT_MAIN  = 2'd1;
  localparam logic [1:0] RT_FINAL = 2'd2;
  localparam logic [3:0] N128 = 4'(AES_128_ROUNDS);
  localparam logic [3:0] N256 = 4'(AES_256_ROUNDS);

  state_e       fsm_q, fsm_d;
  logic [3:0]   ctr_q, ctr_d;
  logic [127:0] st_q, st_d;
  logic [127:0] blk_q, blk_d;
  logic [127:0] res_q, res_d;
  logic         klen_q, klen_d;
  logic         rv_q, rv_d;
  logic [3:0]   nr;

  assign nr             = klen_q ? N256 : N128;
  assign state_out_o    = st_q;
  assign result_o       = res_q;
  assign result_valid_o = rv_q;

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      fsm_q  <= IDLE;
      ctr_q  <= '0;
      st_q   <= '0;
      blk_q  <= '0;
      res_q  <= '0;
      klen_q <= 1'b0;
      rv_q   <= 1'b0;
    end else begin
      fsm_q  <= fsm_d;
      ctr_q  <= ctr_d;
      st_q   <= st_d;
      blk_q  <= blk_d;
      res_q  <= res_d;
      klen_q <= klen_d;
      rv_q   <= rv_d;
    end
  end

  always_comb begin
    fsm_d        = fsm_q;
    ctr_d        = ctr_q;
    st_d         = st_q;
    blk_d        = blk_q;
    res_d        = res_q;
    klen_d       = klen_q;
    rv_d         = rv_q;
    ready_o      = 1'b0;
    round_nr_o   = 4'd0;
    round_type_o = RT_INIT;
    unique case (fsm_q)
      IDLE: begin
        ready_o = 1'b1;
        if (next_i) begin
          blk_d  = block_i;
          klen_d = keylen_i;
          rv_d   = 1'b0;
          fsm_d  = INIT;
        end
      end
      INIT: begin
        st_d  = blk_q ^ round_key_i;
        ctr_d = 4'd1;
        fsm_d = ROUNDS;
      end
      ROUNDS: begin
        round_nr_o   = ctr_q;
        round_type_o = (ctr_q == nr) ? RT_FINAL : RT_MAIN;
        st_d         = round_result_i;
        // Counter parks at zero on the final round instead of stepping past N.
        if (ctr_q == nr) begin
          res_d = round_result_i;
          ctr_d = 4'd0;
          fsm_d = DONE;
        end else begin
          ctr_d = ctr_q + 4'd1;
        end
      end
      DONE: begin
        rv_d  = 1'b1;
        fsm_d = IDLE;
      end
      default: fsm_d = IDLE;
    endcase
  end

endmodule

// File: tb/tb_aes_encipher_ctrl.sv
// Bench for aes_encipher_ctrl: plays key memory and AES round function, and checks
// sequencing, latency and ciphertexts against a software AES model.
module tb_aes_encipher_ctrl;

  logic         clk = 1'b0;
  logic         reset_i, next_i, keylen_i;
  logic [127:0] block_i, round_key, round_result, state_out, result;
  logic [3:0]   round_nr;
  logic [1:0]   round_type;
  logic         ready, result_valid;

  int checks = 0;
  int errors = 0;

  logic [7:0]   sbox [256];
  logic [127:0] rk   [16];

  always #5 clk = ~clk;

  aes_encipher_ctrl dut (
    .clk_i          (clk),
    .reset_i        (reset_i),
    .next_i         (next_i),
    .keylen_i       (keylen_i),
    .block_i        (block_i),
    .round_key_i    (round_key),
    .round_nr_o     (round_nr),
    .round_type_o   (round_type),
    .state_out_o    (state_out),
    .round_result_i (round_result),
    .ready_o        (ready),
    .result_valid_o (result_valid),
    .result_o       (result)
  );

  function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p = 8'h00;
    logic [7:0] x = a;
    for (int i = 0; i < 8; i++) begin
      if (b[i]) p = p ^ x;
      x = {x[6:0], 1'b0} ^ (x[7] ? 8'h1b : 8'h00);
    end
    return p;
  endfunction

  function automatic logic [7:0] sbox_calc(input logic [7:0] x);
    logic [7:0] inv = 8'h00;
    if (x != 8'h00)
      for (int y = 1; y < 256; y++)
        if (gmul(x, 8'(y)) == 8'h01) inv = 8'(y);
    return inv ^ {inv[6:0], inv[7]} ^ {inv[5:0], inv[7:6]} ^
           {inv[4:0], inv[7:5]} ^ {inv[3:0], inv[7:4]} ^ 8'h63;
  endfunction

  // State byte (row r, column c) sits at bits [127-8*(r+4c) -: 8].
  function automatic logic [7:0] sb(input logic [127:0] s, input int r, input int c);
    return s[127-8*(r+4*c) -: 8];
  endfunction

  function automatic logic [127:0] sub_shift(input logic [127:0] s);
    logic [127:0] o;
    for (int c = 0; c < 4; c++)
      for (int r = 0; r < 4; r++)
        o[127-8*(r+4*c) -: 8] = sbox[sb(s, r, (c + r) % 4)];
    return o;
  endfunction

  function automatic logic [127:0] mix(input logic [127:0] s);
    logic [127:0] o;
    for (int c = 0; c < 4; c++)
      for (int r = 0; r < 4; r++)
        o[127-8*(r+4*c) -: 8] = gmul(8'h02, sb(s, r, c)) ^ gmul(8'h03, sb(s, (r+1)%4, c)) ^
                                sb(s, (r+2)%4, c) ^ sb(s, (r+3)%4, c);
    return o;
  endfunction

  function automatic logic [127:0] round_fn(input logic [127:0] s, input logic [127:0] k,
                                            input logic [1:0] t);
    case (t)
      2'd1:    return mix(sub_shift(s)) ^ k;
      2'd2:    return sub_shift(s) ^ k;
      default: return s ^ k;
    endcase
  endfunction

  function automatic logic [31:0] subword(input logic [31:0] w);
    return {sbox[w[31:24]], sbox[w[23:16]], sbox[w[15:8]], sbox[w[7:0]]};
  endfunction

  // Whole-cipher reference: initial key add, N-1 full rounds, final round.
  function automatic logic [127:0] aes_ref(input logic [127:0] blk, input bit k256);
    int n = k256 ? 14 : 10;
    logic [127:0] s = blk ^ rk[0];
    for (int r = 1; r < n; r++) s = round_fn(s, rk[r], 2'd1);
    return round_fn(s, rk[n], 2'd2);
  endfunction

  assign round_key    = rk[round_nr];
  assign round_result = round_fn(state_out, round_key, round_type);

  task automatic expand(input logic [255:0] key, input bit k256);
    logic [31:0] w [60];
    logic [31:0] t;
    logic [7:0]  rc = 8'h01;
    int nk = k256 ? 8 : 4;
    int nw = k256 ? 60 : 44;
    for (int i = 0; i < nk; i++) w[i] = key[255-32*i -: 32];
    for (int i = nk; i < nw; i++) begin
      t = w[i-1];
      if (i % nk == 0) begin
        t  = subword({t[23:0], t[31:24]}) ^ {rc, 24'h0};
        rc = gmul(rc, 8'h02);
      end else if (nk == 8 && i % nk == 4) begin
        t = subword(t);
      end
      w[i] = w[i-nk] ^ t;
    end
    for (int r = 0; r < 16; r++)
      if (4*r + 3 < nw) rk[r] = {w[4*r], w[4*r+1], w[4*r+2], w[4*r+3]};
      else              rk[r] = '0;
  endtask

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Starts from an IDLE cycle (#1 after an edge); returns #1 after the edge that
  // raises result_valid, or after an abort-and-settle sequence.
  task automatic run_op(input string tag, input logic [127:0] blk, input logic [255:0] key,
                        input bit k256, input bit hold, input int poke_at, input int abort_at,
                        input bit use_kat, input logic [127:0] kat);
    logic [127:0] exp_ct;
    int n, exp_nr, exp_rt;
    bit fin;
    expand(key, k256);
    exp_ct   = use_kat ? kat : aes_ref(blk, k256);
    n        = k256 ? 14 : 10;
    block_i  = blk;
    keylen_i = k256;
    next_i   = 1'b1;
    for (int k = 1; k <= n + 3; k++) begin
      @(posedge clk); #1;
      fin    = (k == n + 3);
      exp_nr = (k >= 2 && k <= n + 1) ? k - 1 : 0;
      exp_rt = (k >= 2 && k <= n + 1) ? ((k - 1 == n) ? 2 : 1) : 0;
      chk({tag, "_ready"}, 128'(ready), 128'(fin));
      chk({tag, "_valid"}, 128'(result_valid), 128'(fin));
      chk({tag, "_round_nr"}, 128'(round_nr), 128'(exp_nr));
      chk({tag, "_round_type"}, 128'(round_type), 128'(exp_rt));
      if (k == 2) chk({tag, "_init_state"}, state_out, blk ^ rk[0]);
      if (fin) chk({tag, "_result"}, result, exp_ct);
      if (abort_at > 0 && k - 1 == abort_at) begin
        next_i  = 1'b0;
        reset_i = 1'b1;
        @(posedge clk); #1;
        reset_i = 1'b0;
        chk({tag, "_abort_ready"}, 128'(ready), 128'(1));
        chk({tag, "_abort_result"}, result, '0);
        chk({tag, "_abort_valid"}, 128'(result_valid), 128'(0));
        repeat (16) begin
          @(posedge clk); #1;
          chk({tag, "_abort_novalid"}, 128'(result_valid), 128'(0));
        end
        return;
      end
      if (!fin) begin
        next_i = hold || (poke_at > 0 && k - 1 == poke_at);
        if (k - 1 == poke_at) block_i = ~blk;
        else begin
          block_i  = {$urandom, $urandom, $urandom, $urandom};
          keylen_i = 1'($urandom_range(0, 1));
        end
      end
    end
  endtask

  localparam logic [127:0] PT   = 128'h00112233445566778899aabbccddeeff;
  localparam logic [255:0] K128 = {128'h000102030405060708090a0b0c0d0e0f, 128'h0};
  localparam logic [255:0] K256 = 256'h000102030405060708090a0b0c0d0e0f101112131415161718191a1b1c1d1e1f;
  localparam logic [127:0] CT1  = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;
  localparam logic [127:0] CT3  = 128'h8ea2b7ca516745bfeafc49904b496089;

  initial begin
    for (int i = 0; i < 256; i++) sbox[i] = sbox_calc(8'(i));
    for (int r = 0; r < 16; r++) rk[r] = '0;
    reset_i  = 1'b1;
    next_i   = 1'b0;
    keylen_i = 1'b0;
    block_i  = '0;
    repeat (2) @(posedge clk);
    #1;
    reset_i = 1'b0;
    chk("rst_ready", 128'(ready), 128'(1));
    chk("rst_valid", 128'(result_valid), 128'(0));
    chk("rst_result", result, '0);
    chk("rst_round_nr", 128'(round_nr), 128'(0));
    chk("rst_round_type", 128'(round_type), 128'(0));
    chk("rst_state", state_out, '0);

    run_op("c1", PT, K128, 1'b0, 1'b0, 0, 0, 1'b1, CT1);
    block_i = ~PT;
    repeat (3) begin
      @(posedge clk); #1;
      chk("hold_valid", 128'(result_valid), 128'(1));
      chk("hold_result", result, CT1);
    end

    run_op("c3", PT, K256, 1'b1, 1'b0, 0, 0, 1'b1, CT3);
    run_op("busy", PT, K128, 1'b0, 1'b0, 5, 0, 1'b1, CT1);
    @(posedge clk); #1;
    chk("busy_no_second", 128'(ready), 128'(1));
    chk("busy_no_second_nr", 128'(round_nr), 128'(0));

    run_op("abort", PT, K128, 1'b0, 1'b0, 0, 7, 1'b1, CT1);
    run_op("fresh", PT, K128, 1'b0, 1'b0, 0, 0, 1'b1, CT1);

    run_op("b2b_a", PT, K128, 1'b0, 1'b1, 0, 0, 1'b1, CT1);
    run_op("b2b_b", PT, K128, 1'b0, 1'b0, 0, 0, 1'b1, CT1);

    for (int i = 0; i < 8; i++)
      run_op("rand", {$urandom, $urandom, $urandom, $urandom},
             {$urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom},
             1'($urandom_range(0, 1)), 1'b0, 0, 0, 1'b0, '0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
